// File: rtl/azimuth_signal_generator_mc_pkg.sv
// Shared types and helpers for the multi-channel azimuth pattern generator.
// Pure declarations: no latency, no flow control.
package azimuth_signal_generator_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/azimuth_signal_generator_mc_edge_sync.sv
// Synchronises an async level and emits a one-cycle rise pulse STAGES cycles after sampling it high.
// No backpressure; edges seen before the chain has filled after reset are discarded.
module azimuth_signal_generator_mc_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;
    logic [STAGES:0]   fill_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            hist_q <= sync_q[STAGES-1];
            fill_q <= {fill_q[STAGES-1:0], 1'b1};
        end
    end

    // fill_q guards against a level that was already high when reset released
    assign rise_o = sync_q[STAGES-1] & ~hist_q & fill_q[STAGES];

endmodule

// File: rtl/azimuth_signal_generator_mc.sv
// Double-buffered multi-channel azimuth pattern player; bin index steps on CLK, restarts on TRIG.
// GEN_SIGNAL lags BIN_IDX by one cycle (registered RAM read); the write port never stalls.
module azimuth_signal_generator_mc
    import azimuth_signal_generator_mc_pkg::*;
#(
    parameter int SIZE        = 3200,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    localparam int BITS       = clog2(SIZE + 1)
) (
    input  logic                SYS_CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                TRIG,
    input  logic                CLK,
    input  logic                WR_EN,
    input  logic [BITS-1:0]     WR_ADDR,
    input  logic [CHANNELS-1:0] WR_DATA,
    input  logic                WR_COMMIT,
    output logic [CHANNELS-1:0] GEN_SIGNAL,
    output logic [BITS-1:0]     BIN_IDX,
    output logic                SWAP_PENDING,
    output logic                OVERRUN,
    output logic                WR_ERR
);

    localparam logic [BITS-1:0] SIZE_V = BITS'(SIZE);
    localparam int              DEPTH  = 1 << (BITS + 1);

    logic trig_rise;
    logic clk_rise;

    azimuth_signal_generator_mc_edge_sync #(.STAGES(SYNC_STAGES)) u_trig_sync (
        .clk_i   (SYS_CLK),
        .rst_i   (RST),
        .async_i (TRIG),
        .rise_o  (trig_rise)
    );

    azimuth_signal_generator_mc_edge_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk_i   (SYS_CLK),
        .rst_i   (RST),
        .async_i (CLK),
        .rise_o  (clk_rise)
    );

    state_e              state_q;
    logic [BITS-1:0]     idx_q;
    logic                overrun_q;
    logic                active_bank_q, active_bank_d;
    logic                swap_pending_q, swap_pending_d;
    logic                wr_err_q, wr_err_d;
    logic [CHANNELS-1:0] gen_q;
    logic [BITS-1:0]     idx_inc;
    logic                wr_ok;

    // Both banks share one array addressed by {bank, bin}
    logic [CHANNELS-1:0] pattern_mem [DEPTH];

    assign idx_inc = idx_q + BITS'(1);
    assign wr_ok   = WR_EN && (WR_ADDR < SIZE_V);

    always_ff @(posedge SYS_CLK) begin
        if (wr_ok) begin
            pattern_mem[{~active_bank_q, WR_ADDR}] <= WR_DATA;
        end
    end

    always_comb begin
        active_bank_d  = active_bank_q;
        swap_pending_d = swap_pending_q;
        wr_err_d       = wr_err_q;
        if (trig_rise) begin
            if (swap_pending_q) begin
                active_bank_d = ~active_bank_q;
            end
            swap_pending_d = WR_COMMIT;
        end else if (WR_COMMIT) begin
            swap_pending_d = 1'b1;
        end
        if (WR_EN && !wr_ok) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            wr_err_q       <= 1'b0;
        end else begin
            active_bank_q  <= active_bank_d;
            swap_pending_q <= swap_pending_d;
            wr_err_q       <= wr_err_d;
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            idx_q     <= SIZE_V;
            overrun_q <= 1'b0;
        end else if (trig_rise) begin
            // A coincident bin edge counts as the first step of the new sweep
            idx_q     <= clk_rise ? BITS'(1) : '0;
            state_q   <= (clk_rise && SIZE_V == BITS'(1)) ? ST_DONE : ST_RUN;
            overrun_q <= 1'b0;
        end else if (clk_rise) begin
            unique case (state_q)
                ST_RUN: begin
                    idx_q <= idx_inc;
                    if (idx_inc == SIZE_V) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    idx_q     <= SIZE_V;
                    overrun_q <= 1'b1;
                end
                default: begin
                    idx_q <= idx_q;
                end
            endcase
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            gen_q <= '0;
        end else if (EN && (idx_q < SIZE_V)) begin
            gen_q <= pattern_mem[{active_bank_q, idx_q}];
        end else begin
            gen_q <= '0;
        end
    end

    assign GEN_SIGNAL   = gen_q;
    assign BIN_IDX      = idx_q;
    assign SWAP_PENDING = swap_pending_q;
    assign OVERRUN      = overrun_q;
    assign WR_ERR       = wr_err_q;

endmodule

// File: tb/tb_azimuth_signal_generator_mc.sv
// Bench for azimuth_signal_generator_mc: directed scenarios with literal expectations,
// then randomized stimulus, all compared every cycle against a behavioural model.
module tb_azimuth_signal_generator_mc;

    localparam int SIZE = 8;
    localparam int CH   = 2;
    localparam int SS   = 2;
    localparam int BITS = 4;

    logic            SYS_CLK;
    logic            RST;
    logic            EN;
    logic            TRIG;
    logic            CLK;
    logic            WR_EN;
    logic [BITS-1:0] WR_ADDR;
    logic [CH-1:0]   WR_DATA;
    logic            WR_COMMIT;
    logic [CH-1:0]   GEN_SIGNAL;
    logic [BITS-1:0] BIN_IDX;
    logic            SWAP_PENDING;
    logic            OVERRUN;
    logic            WR_ERR;

    azimuth_signal_generator_mc #(
        .SIZE        (SIZE),
        .CHANNELS    (CH),
        .SYNC_STAGES (SS)
    ) dut (
        .SYS_CLK      (SYS_CLK),
        .RST          (RST),
        .EN           (EN),
        .TRIG         (TRIG),
        .CLK          (CLK),
        .WR_EN        (WR_EN),
        .WR_ADDR      (WR_ADDR),
        .WR_DATA      (WR_DATA),
        .WR_COMMIT    (WR_COMMIT),
        .GEN_SIGNAL   (GEN_SIGNAL),
        .BIN_IDX      (BIN_IDX),
        .SWAP_PENDING (SWAP_PENDING),
        .OVERRUN      (OVERRUN),
        .WR_ERR       (WR_ERR)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_idx = SIZE;
    bit       m_armed = 0;
    bit       m_bank = 0, m_pend = 0, m_ovr = 0, m_err = 0;
    int       m_gen = 0;
    bit       m_gen_known = 1;
    int       m_mem [2][SIZE];
    bit       m_known [2][SIZE];
    bit       th [SS+2];
    bit       ch [SS+2];
    int       m_k = 0;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < SIZE; a++) begin
                m_mem[b][a]   = 0;
                m_known[b][a] = 0;
            end
        for (int j = 0; j < SS + 2; j++) begin
            th[j] = 0;
            ch[j] = 0;
        end
        forever begin
            @(posedge SYS_CLK or posedge RST);
            if (RST) begin
                m_idx = SIZE; m_armed = 0; m_bank = 0; m_pend = 0;
                m_ovr = 0; m_err = 0; m_gen = 0; m_gen_known = 1; m_k = 0;
                for (int j = 0; j < SS + 2; j++) begin
                    th[j] = 0;
                    ch[j] = 0;
                end
            end else begin
                bit tr, cr;
                m_k++;
                for (int j = SS + 1; j > 0; j--) begin
                    th[j] = th[j-1];
                    ch[j] = ch[j-1];
                end
                th[0] = TRIG;
                ch[0] = CLK;
                // an input rise sampled here becomes an internal event SS samples later
                tr = (m_k >= SS + 2) && th[SS] && !th[SS+1];
                cr = (m_k >= SS + 2) && ch[SS] && !ch[SS+1];
                if (EN && m_idx < SIZE) begin
                    m_gen       = m_mem[m_bank][m_idx];
                    m_gen_known = m_known[m_bank][m_idx];
                end else begin
                    m_gen       = 0;
                    m_gen_known = 1;
                end
                if (WR_EN) begin
                    if (int'(WR_ADDR) < SIZE) begin
                        m_mem[!m_bank][WR_ADDR]   = int'(WR_DATA);
                        m_known[!m_bank][WR_ADDR] = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                if (tr) begin
                    if (m_pend) m_bank = !m_bank;
                    m_pend  = WR_COMMIT;
                    m_idx   = cr ? 1 : 0;
                    m_ovr   = 0;
                    m_armed = 1;
                end else begin
                    if (WR_COMMIT) m_pend = 1;
                    if (cr && m_armed) begin
                        if (m_idx < SIZE) m_idx++;
                        else m_ovr = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge SYS_CLK);
            #1;
            if (chk_en) begin
                if (m_gen_known) chk("gen_signal", GEN_SIGNAL, m_gen);
                chk("bin_idx", BIN_IDX, m_idx);
                chk("swap_pending", SWAP_PENDING, m_pend);
                chk("overrun", OVERRUN, m_ovr);
                chk("wr_err", WR_ERR, m_err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge SYS_CLK);
    endtask

    task automatic clk_pulse();
        CLK = 1'b1; cyc(4);
        CLK = 1'b0; cyc(4);
    endtask

    task automatic trig_pulse();
        TRIG = 1'b1; cyc(4);
        TRIG = 1'b0; cyc(4);
    endtask

    task automatic wr(input int a, input int d);
        WR_EN = 1'b1; WR_ADDR = BITS'(a); WR_DATA = CH'(d);
        cyc(1);
        WR_EN = 1'b0;
    endtask

    task automatic commit();
        WR_COMMIT = 1'b1; cyc(1);
        WR_COMMIT = 1'b0;
    endtask

    initial begin
        int tcnt, ccnt;
        RST = 1'b1; EN = 1'b1; TRIG = 1'b0; CLK = 1'b0;
        WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; WR_COMMIT = 1'b0;
        cyc(3);
        RST = 1'b0;
        chk_en = 1'b1;
        cyc(2);
        chk("reset gen", GEN_SIGNAL, 0);
        chk("reset idx", BIN_IDX, SIZE);
        chk("reset pending", SWAP_PENDING, 0);
        chk("reset overrun", OVERRUN, 0);
        chk("reset wr_err", WR_ERR, 0);

        // pattern load and play
        for (int k = 0; k < SIZE; k++) wr(k, k & 3);
        commit();
        chk("commit pending", SWAP_PENDING, 1);
        trig_pulse();
        chk("play idx0", BIN_IDX, 0);
        chk("play pending cleared", SWAP_PENDING, 0);
        chk("play gen0", GEN_SIGNAL, 0);
        for (int i = 1; i <= SIZE; i++) begin
            clk_pulse();
            chk("play gen", GEN_SIGNAL, (i < SIZE) ? (i % 4) : 0);
        end
        chk("play end idx", BIN_IDX, SIZE);

        // overrun
        clk_pulse();
        clk_pulse();
        chk("overrun set", OVERRUN, 1);
        chk("overrun idx", BIN_IDX, SIZE);
        chk("overrun gen", GEN_SIGNAL, 0);
        trig_pulse();
        chk("overrun cleared", OVERRUN, 0);
        chk("retrig idx", BIN_IDX, 0);

        // atomic swap mid-sweep
        clk_pulse();
        chk("swap old gen1", GEN_SIGNAL, 1);
        for (int k = 0; k < SIZE; k++) wr(k, 3);
        commit();
        clk_pulse();
        chk("swap old gen2", GEN_SIGNAL, 2);
        chk("swap pending", SWAP_PENDING, 1);
        trig_pulse();
        chk("swap pending cleared", SWAP_PENDING, 0);
        chk("swap new gen0", GEN_SIGNAL, 3);
        clk_pulse();
        chk("swap new gen1", GEN_SIGNAL, 3);

        // simultaneous TRIG/CLK with coincident commit
        for (int k = 0; k < SIZE; k++) wr(k, 1);
        commit();
        TRIG = 1'b1; CLK = 1'b1;
        cyc(2);
        WR_COMMIT = 1'b1;
        cyc(1);
        WR_COMMIT = 1'b0;
        cyc(3);
        TRIG = 1'b0; CLK = 1'b0;
        cyc(4);
        chk("simul idx", BIN_IDX, 1);
        chk("simul pending kept", SWAP_PENDING, 1);
        chk("simul gen", GEN_SIGNAL, 1);
        trig_pulse();
        chk("simul reswap pending", SWAP_PENDING, 0);
        chk("simul reswap gen", GEN_SIGNAL, 3);

        // EN gating
        EN = 1'b0;
        clk_pulse();
        chk("gate gen off", GEN_SIGNAL, 0);
        chk("gate idx advances", BIN_IDX, 1);
        EN = 1'b1;
        chk("gate latency", GEN_SIGNAL, 0);
        cyc(1);
        chk("gate gen on", GEN_SIGNAL, 3);

        // out-of-range write
        wr(SIZE, 0);
        chk("wr_err set", WR_ERR, 1);
        commit();
        trig_pulse();
        chk("wr_err mem intact", GEN_SIGNAL, 1);
        chk("wr_err sticky", WR_ERR, 1);

        // reset mid-sweep with CLK held high
        clk_pulse(); clk_pulse(); clk_pulse();
        chk("pre-reset idx", BIN_IDX, 3);
        CLK = 1'b1;
        cyc(2);
        RST = 1'b1;
        #1;
        chk("midrst gen", GEN_SIGNAL, 0);
        chk("midrst idx", BIN_IDX, SIZE);
        chk("midrst pending", SWAP_PENDING, 0);
        chk("midrst overrun", OVERRUN, 0);
        chk("midrst wr_err", WR_ERR, 0);
        cyc(2);
        RST = 1'b0;
        cyc(4);
        trig_pulse();
        cyc(4);
        chk("held clk no edge", BIN_IDX, 0);
        CLK = 1'b0; cyc(4);
        CLK = 1'b1; cyc(4);
        chk("clk edge after low", BIN_IDX, 1);
        CLK = 1'b0; cyc(4);

        // randomized phase
        tcnt = 20; ccnt = 4;
        for (int n = 0; n < 3000; n++) begin
            if (tcnt == 0) begin
                TRIG = ~TRIG;
                tcnt = TRIG ? $urandom_range(3, 8) : $urandom_range(30, 150);
            end else tcnt--;
            if (ccnt == 0) begin
                CLK  = ~CLK;
                ccnt = $urandom_range(3, 7);
            end else ccnt--;
            WR_EN     = ($urandom % 3) == 0;
            WR_ADDR   = BITS'($urandom_range(0, SIZE + 1));
            WR_DATA   = CH'($urandom);
            WR_COMMIT = ($urandom % 40) == 0;
            EN        = ($urandom % 16) != 0;
            RST       = (n >= 1500 && n < 1503);
            cyc(1);
        end
        WR_EN = 1'b0; WR_COMMIT = 1'b0; RST = 1'b0;
        cyc(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
